// File: rtl/pattern_sequencer.sv
// pattern_sequencer: multi-channel serial pattern player.
// Each channel holds a PAT_LEN-bit pattern and shifts it out LSB first,
// one bit per (div+1) cycles, either once (oneshot) or looping forever.
// A free-running counter provides a divided tick output.
//
// Ports:
//   CLK, RST     clock (rising edge) and asynchronous active-high reset
//   cfg_valid    configuration offered
//   cfg_ready    configuration accepted (1 from the first edge after reset)
//   cfg_chan     target channel; values >= CHANNELS are accepted and dropped
//   cfg_pattern  pattern, bit 0 shown first
//   cfg_div      step length is cfg_div+1 cycles
//   cfg_oneshot  1 = play once, 0 = loop
//   cfg_idle     output level while the channel is idle
//   stop         per-channel abort (ignored while idle)
//   ch_out       registered pattern outputs
//   ch_busy      channel is running
//   ch_done      one-cycle pulse when a oneshot run completes
//   tick_out     bit TICK_BIT of a free-running counter

// One channel: IDLE/RUN state machine with prescaler and bit index.
module pattern_sequencer_lane #(
   parameter int PAT_LEN = 32,
   parameter int DIV_W   = 26
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               load,
   input  logic [PAT_LEN-1:0] pattern,
   input  logic [DIV_W-1:0]   div,
   input  logic               oneshot,
   input  logic               idle_lvl,
   input  logic               stop,
   output logic               out,
   output logic               busy,
   output logic               done
);
   localparam int IDX_W = $clog2(PAT_LEN);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(PAT_LEN - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             state_q, state_d;
   logic [PAT_LEN-1:0] pat_q, pat_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [DIV_W-1:0]   pre_q, pre_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               os_q, os_d;
   logic               idl_q, idl_d;
   logic               out_q, out_d;
   logic               done_q, done_d;
   logic               step, last;

   assign step = (state_q == S_RUN) && (pre_q == '0);
   assign last = (idx_q == LAST);

   // State register (plus datapath registers)
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         pat_q   <= '0;
         div_q   <= '0;
         pre_q   <= '0;
         idx_q   <= '0;
         os_q    <= 1'b0;
         idl_q   <= 1'b0;
         out_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         div_q   <= div_d;
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         os_q    <= os_d;
         idl_q   <= idl_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

   // Next state: a load wins over stop and over the final oneshot step.
   always_comb begin
      state_d = state_q;
      if (load)
         state_d = S_RUN;
      else if (state_q == S_RUN) begin
         if (stop)
            state_d = S_IDLE;
         else if (step && last && os_q)
            state_d = S_IDLE;
      end
   end

   // Datapath and registered outputs
   always_comb begin
      pat_d  = pat_q;
      div_d  = div_q;
      pre_d  = pre_q;
      idx_d  = idx_q;
      os_d   = os_q;
      idl_d  = idl_q;
      out_d  = out_q;
      done_d = 1'b0;
      if (load) begin
         pat_d = pattern;
         div_d = div;
         pre_d = div;
         idx_d = '0;
         os_d  = oneshot;
         idl_d = idle_lvl;
         out_d = pattern[0];
      end else if (state_q == S_RUN) begin
         if (stop)
            out_d = idl_q;
         else if (!step)
            pre_d = pre_q - DIV_W'(1);
         else begin
            pre_d = div_q;
            if (last) begin
               idx_d = '0;
               if (os_q) begin
                  out_d  = idl_q;
                  done_d = 1'b1;
               end else
                  out_d = pat_q[0];
            end else begin
               idx_d = idx_q + IDX_W'(1);
               out_d = pat_q[idx_d];
            end
         end
      end
   end

   assign out  = out_q;
   assign busy = (state_q == S_RUN);
   assign done = done_q;
endmodule

module pattern_sequencer #(
   parameter int CHANNELS = 2,
   parameter int PAT_LEN  = 32,
   parameter int DIV_W    = 26,
   parameter int TICK_BIT = 3,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_chan,
   input  logic [PAT_LEN-1:0]  cfg_pattern,
   input  logic [DIV_W-1:0]    cfg_div,
   input  logic                cfg_oneshot,
   input  logic                cfg_idle,
   input  logic [CHANNELS-1:0] stop,
   output logic [CHANNELS-1:0] ch_out,
   output logic [CHANNELS-1:0] ch_busy,
   output logic [CHANNELS-1:0] ch_done,
   output logic                tick_out
);
   logic              ready_q;
   logic [TICK_BIT:0] tick_cnt_q;
   logic              xfer;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ready_q    <= 1'b0;
         tick_cnt_q <= '0;
      end else begin
         ready_q    <= 1'b1;
         tick_cnt_q <= tick_cnt_q + (TICK_BIT+1)'(1);
      end
   end

   assign cfg_ready = ready_q;
   assign tick_out  = tick_cnt_q[TICK_BIT];
   assign xfer      = cfg_valid && ready_q;

   // An out-of-range cfg_chan matches no lane, so the transfer completes
   // without touching any channel.
   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      pattern_sequencer_lane #(
         .PAT_LEN (PAT_LEN),
         .DIV_W   (DIV_W)
      ) u_lane (
         .CLK      (CLK),
         .RST      (RST),
         .load     (xfer && (cfg_chan == CH_W'(g))),
         .pattern  (cfg_pattern),
         .div      (cfg_div),
         .oneshot  (cfg_oneshot),
         .idle_lvl (cfg_idle),
         .stop     (stop[g]),
         .out      (ch_out[g]),
         .busy     (ch_busy[g]),
         .done     (ch_done[g])
      );
   end
endmodule

// File: tb/tb_pattern_sequencer.sv
module tb_pattern_sequencer;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [0:0]  cfg_chan = '0;
   logic [31:0] cfg_pattern = '0;
   logic [25:0] cfg_div = '0;
   logic        cfg_oneshot = 1'b0;
   logic        cfg_idle = 1'b0;
   logic [1:0]  stop = '0;
   logic [1:0]  ch_out, ch_busy, ch_done;
   logic        tick_out;

   // Second instance with three channels so that cfg_chan = 3 is encodable
   // but out of range.
   logic        c3_valid = 1'b0;
   logic        c3_ready;
   logic [1:0]  c3_chan = '0;
   logic [2:0]  c3_stop = '0;
   logic [2:0]  c3_out, c3_busy, c3_done;
   logic        c3_tick;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   pattern_sequencer dut (
      .CLK(CLK), .RST(RST), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_chan(cfg_chan), .cfg_pattern(cfg_pattern), .cfg_div(cfg_div),
      .cfg_oneshot(cfg_oneshot), .cfg_idle(cfg_idle), .stop(stop),
      .ch_out(ch_out), .ch_busy(ch_busy), .ch_done(ch_done), .tick_out(tick_out)
   );

   pattern_sequencer #(.CHANNELS(3)) dut3 (
      .CLK(CLK), .RST(RST), .cfg_valid(c3_valid), .cfg_ready(c3_ready),
      .cfg_chan(c3_chan), .cfg_pattern(cfg_pattern), .cfg_div(cfg_div),
      .cfg_oneshot(cfg_oneshot), .cfg_idle(cfg_idle), .stop(c3_stop),
      .ch_out(c3_out), .ch_busy(c3_busy), .ch_done(c3_done), .tick_out(c3_tick)
   );

   typedef struct {
      logic        v;
      logic        ch;
      logic [31:0] pat;
      logic [25:0] dv;
      logic        os;
      logic        il;
      logic [1:0]  st;
      logic [1:0]  e_out;
      logic [1:0]  e_busy;
      logic [1:0]  e_done;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clr_inputs();
      cfg_valid = 1'b0;
      c3_valid  = 1'b0;
      stop      = '0;
      c3_stop   = '0;
   endtask

   task automatic cfg(input logic ch, input logic [31:0] pat, input logic [25:0] dv,
                      input logic os, input logic il);
      cfg_valid   = 1'b1;
      cfg_chan    = ch;
      cfg_pattern = pat;
      cfg_div     = dv;
      cfg_oneshot = os;
      cfg_idle    = il;
   endtask

   // Reset asserted mid-cycle: outputs must clear without waiting for a clock.
   task automatic do_reset(input string name);
      step();
      RST = 1'b1;
      #1;
      chk({name, "_async"}, {23'd0, cfg_ready, tick_out, ch_done, ch_busy, ch_out}, 32'd0);
      step();
      step();
      chk({name, "_held"}, {20'd0, c3_ready, c3_out, c3_busy, c3_done, cfg_ready, tick_out,
                            ch_done, ch_busy, ch_out}, 32'd0);
      RST = 1'b0;
      chk({name, "_ready0"}, {31'd0, cfg_ready}, 32'd0);
      step();
      chk({name, "_ready1"}, {31'd0, cfg_ready}, 32'd1);
   endtask

   vec_t tbl [9];

   initial begin
      logic [31:0] p;
      int k;

      // Single-cycle vectors: driven inputs, then outputs after that edge.
      tbl[0] = '{1'b1, 1'b0, 32'h0000000A, 26'd0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 2'b00};
      tbl[1] = '{1'b0, 1'b0, 32'h0,        26'd0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00};
      tbl[2] = '{1'b0, 1'b0, 32'h0,        26'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00};
      tbl[3] = '{1'b1, 1'b1, 32'h00000003, 26'd1, 1'b1, 1'b0, 2'b00, 2'b11, 2'b11, 2'b00};
      tbl[4] = '{1'b0, 1'b0, 32'h0,        26'd0, 1'b0, 1'b0, 2'b01, 2'b11, 2'b10, 2'b00};
      tbl[5] = '{1'b0, 1'b0, 32'h0,        26'd0, 1'b0, 1'b0, 2'b01, 2'b11, 2'b10, 2'b00};
      tbl[6] = '{1'b0, 1'b0, 32'h0,        26'd0, 1'b0, 1'b0, 2'b11, 2'b01, 2'b00, 2'b00};
      tbl[7] = '{1'b1, 1'b0, 32'h00000001, 26'd0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00};
      tbl[8] = '{1'b0, 1'b0, 32'h0,        26'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00};

      // Reset from time zero
      step();
      step();
      chk("rst_outs", {23'd0, cfg_ready, tick_out, ch_done, ch_busy, ch_out}, 32'd0);
      RST = 1'b0;
      chk("rst_ready_pre", {31'd0, cfg_ready}, 32'd0);

      // tick_out: counter equals the number of edges since release
      for (int j = 1; j <= 32; j++) begin
         step();
         chk($sformatf("tick_%0d", j), {30'd0, cfg_ready, tick_out},
             {30'd0, 1'b1, ((j % 16) >= 8) ? 1'b1 : 1'b0});
      end

      // Table-driven vectors
      for (int i = 0; i < 9; i++) begin
         cfg_valid   = tbl[i].v;
         cfg_chan    = tbl[i].ch;
         cfg_pattern = tbl[i].pat;
         cfg_div     = tbl[i].dv;
         cfg_oneshot = tbl[i].os;
         cfg_idle    = tbl[i].il;
         stop        = tbl[i].st;
         step();
         chk($sformatf("vec_%0d", i), {26'd0, ch_done, ch_busy, ch_out},
             {26'd0, tbl[i].e_done, tbl[i].e_busy, tbl[i].e_out});
      end
      clr_inputs();

      // Channel 0 is still running: reset mid-run discards it
      do_reset("midrun");
      chk("midrun_after", {26'd0, ch_done, ch_busy, ch_out}, 32'd0);

      // Loop: 0x5, div 2 -> bit k held 3 cycles, repeats every 96
      p = 32'h00000005;
      cfg(1'b0, p, 26'd2, 1'b0, 1'b0);
      step();
      clr_inputs();
      for (int t = 0; t < 200; t++) begin
         k = (t / 3) % 32;
         chk($sformatf("loop_t%0d", t), {26'd0, ch_done, ch_busy, ch_out},
             {26'd0, 2'b00, 2'b01, 1'b0, p[k]});
         step();
      end

      // Oneshot: all ones, div 0, on channel 1
      do_reset("os");
      cfg(1'b1, 32'hFFFFFFFF, 26'd0, 1'b1, 1'b0);
      step();
      clr_inputs();
      for (int t = 0; t < 32; t++) begin
         chk($sformatf("os_t%0d", t), {26'd0, ch_done, ch_busy, ch_out},
             {26'd0, 2'b00, 2'b10, 2'b10});
         step();
      end
      chk("os_done", {26'd0, ch_done, ch_busy, ch_out}, {26'd0, 2'b10, 2'b00, 2'b00});
      step();
      chk("os_done_once", {26'd0, ch_done, ch_busy, ch_out}, 32'd0);

      // Collision: new transfer on the edge of the final oneshot step
      do_reset("col");
      cfg(1'b1, 32'hFFFFFFFF, 26'd0, 1'b1, 1'b0);
      step();
      clr_inputs();
      for (int t = 0; t < 31; t++) step();
      chk("col_pre", {26'd0, ch_done, ch_busy, ch_out}, {26'd0, 2'b00, 2'b10, 2'b10});
      cfg(1'b1, 32'h00000002, 26'd0, 1'b1, 1'b0);
      step();
      clr_inputs();
      chk("col_restart", {26'd0, ch_done, ch_busy, ch_out}, {26'd0, 2'b00, 2'b10, 2'b00});
      step();
      chk("col_bit1", {26'd0, ch_done, ch_busy, ch_out}, {26'd0, 2'b00, 2'b10, 2'b10});

      // Stop at bit 5 of a loop run with idle level 1
      do_reset("stp");
      cfg(1'b0, 32'h00000000, 26'd1, 1'b0, 1'b1);
      step();
      clr_inputs();
      for (int t = 0; t < 10; t++) step();
      chk("stp_bit5", {26'd0, ch_done, ch_busy, ch_out}, {26'd0, 2'b00, 2'b01, 2'b00});
      stop = 2'b01;
      step();
      chk("stp_idle", {26'd0, ch_done, ch_busy, ch_out}, {26'd0, 2'b00, 2'b00, 2'b01});
      step();
      chk("stp_hold", {26'd0, ch_done, ch_busy, ch_out}, {26'd0, 2'b00, 2'b00, 2'b01});
      clr_inputs();

      // Illegal channel on the three-channel instance
      do_reset("ill");
      c3_valid    = 1'b1;
      c3_chan     = 2'd3;
      cfg_pattern = 32'hFFFFFFFF;
      cfg_div     = 26'd0;
      cfg_oneshot = 1'b0;
      cfg_idle    = 1'b1;
      chk("ill_ready", {31'd0, c3_ready}, 32'd1);
      step();
      c3_valid = 1'b0;
      chk("ill_none", {23'd0, c3_done, c3_busy, c3_out}, 32'd0);
      step();
      chk("ill_still", {23'd0, c3_done, c3_busy, c3_out}, 32'd0);
      c3_valid = 1'b1;
      c3_chan  = 2'd2;
      step();
      clr_inputs();
      chk("ill_legal2", {23'd0, c3_done, c3_busy, c3_out}, {23'd0, 3'b000, 3'b100, 3'b100});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
